nf10_axis_stream_monitor: RTL and testbench

Parametrised AXI4-Stream sink/tap that supersedes the fixed-width record block used in the behavioural testbenches. It counts packets and bytes and reports the last packet length. It can also generate pseudo-random backpressure, check stream protocol rules with sticky error flags, and stretch an activity indication. It sits on any output-queue or DMA-side master port in simulation, and is synthesisable for on-board debug taps.

---
 rtl/nf10_axis_stream_monitor.sv | 188 ++++++++++++++++++
 tb/tb_nf10_axis_stream_monitor.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_axis_stream_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nf10_axis_stream_monitor
// Brief    : AXI4-Stream sink/tap with packet/byte statistics, optional LFSR
//            backpressure, sticky protocol error flags and activity stretch.
//            Define NF10_AXIS_MON_LEN_CHECK_EN to enable the tuser length check.
// Revision : 1.0 - initial release
// ============================================================================
module nf10_axis_stream_monitor #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          C_COUNTER_WIDTH      = 8,
    parameter int          C_BYTE_COUNT_WIDTH   = 32,
    parameter int          C_TREADY_MODE        = 0,
    parameter logic [15:0] C_LFSR_SEED          = 16'hACE1,
    parameter int          C_ACTIVITY_HOLD      = 16
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              clear_stats,
    output logic [C_COUNTER_WIDTH-1:0]        pkt_count,
    output logic [C_BYTE_COUNT_WIDTH-1:0]     byte_count,
    output logic [15:0]                       last_pkt_len,
    output logic                              activity_rec,
    output logic [3:0]                        err
);

    localparam int c_STRB_W  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int c_SUM_W   = ((C_BYTE_COUNT_WIDTH > 17) ? C_BYTE_COUNT_WIDTH : 17) + 1;
    localparam int c_HOLD_W  = $clog2(C_ACTIVITY_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(C_ACTIVITY_HOLD);
    localparam logic [15:0]         c_LFSR_TAPS = 16'hB400;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_IN_PKT = 1'b1;

    logic [0:0]                      r_state;
    logic [16:0]                     r_pkt_bytes;
    logic [C_COUNTER_WIDTH-1:0]      r_pkt_count;
    logic [C_BYTE_COUNT_WIDTH-1:0]   r_byte_count;
    logic [15:0]                     r_last_pkt_len;
    logic [3:0]                      r_err;
    logic [c_HOLD_W-1:0]             r_hold;
    logic                            r_tready;
    logic [15:0]                     r_lfsr;
    logic                            r_stalled;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  r_prev_tdata;
    logic [c_STRB_W-1:0]             r_prev_tstrb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] r_prev_tuser;
    logic                            r_prev_tlast;

    logic                            w_beat;
    logic                            w_first;
    logic [16:0]                     w_beat_bytes;
    logic [16:0]                     w_pkt_len;
    logic                            w_strb_bad;
    logic                            w_tvalid_drop;
    logic                            w_stall_change;
    logic                            w_len_err;
    logic [c_SUM_W-1:0]              w_byte_sum;
    logic [C_BYTE_COUNT_WIDTH-1:0]   w_byte_sat;
    logic [15:0]                     w_lfsr_next;
    logic                            w_tready_next;

    assign w_beat  = s_axis_tvalid & r_tready;
    assign w_first = (r_state == c_ST_IDLE);

    always_comb begin
        w_beat_bytes = 17'd0;
        for (int i = 0; i < c_STRB_W; i++) begin
            w_beat_bytes = w_beat_bytes + 17'(s_axis_tstrb[i]);
        end
    end

    // The first beat of a packet loads the length directly, later beats accumulate.
    assign w_pkt_len = w_first ? w_beat_bytes : (r_pkt_bytes + w_beat_bytes);

    assign w_strb_bad = (s_axis_tstrb != '0)
                      ? ((s_axis_tstrb & (s_axis_tstrb + c_STRB_W'(1))) != '0)
                      : ~s_axis_tlast;

    assign w_tvalid_drop  = r_stalled & ~s_axis_tvalid;
    assign w_stall_change = r_stalled & s_axis_tvalid &
                            ((s_axis_tdata != r_prev_tdata) || (s_axis_tstrb != r_prev_tstrb) ||
                             (s_axis_tlast != r_prev_tlast) || (s_axis_tuser != r_prev_tuser));

    assign w_byte_sum = {{(c_SUM_W-C_BYTE_COUNT_WIDTH){1'b0}}, r_byte_count}
                      + {{(c_SUM_W-17){1'b0}}, w_pkt_len};
    assign w_byte_sat = (w_byte_sum[c_SUM_W-1:C_BYTE_COUNT_WIDTH] != '0)
                      ? {C_BYTE_COUNT_WIDTH{1'b1}}
                      : w_byte_sum[C_BYTE_COUNT_WIDTH-1:0];

`ifdef NF10_AXIS_MON_LEN_CHECK_EN
    logic [15:0] r_len_latched;
    logic [15:0] w_exp_len;

    // A single-beat packet compares against the length presented on that same beat.
    assign w_exp_len = w_first ? s_axis_tuser[15:0] : r_len_latched;
    assign w_len_err = w_beat & s_axis_tlast & (w_pkt_len != {1'b0, w_exp_len});

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_len_latched <= 16'd0;
        end else if (w_beat && w_first) begin
            r_len_latched <= s_axis_tuser[15:0];
        end
    end
`else
    assign w_len_err = 1'b0;
`endif

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_TAPS) : (r_lfsr >> 1);

    generate
        if (C_TREADY_MODE == 0) begin : g_tready_always
            assign w_tready_next = 1'b1;
        end else begin : g_tready_lfsr
            assign w_tready_next = (r_lfsr[1:0] != 2'b00);
        end
    endgenerate

    // Backpressure, activity stretch and stall tracking are untouched by clear_stats.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_tready  <= 1'b0;
            r_lfsr    <= C_LFSR_SEED;
            r_hold    <= '0;
            r_stalled <= 1'b0;
        end else begin
            r_tready  <= w_tready_next;
            r_lfsr    <= w_lfsr_next;
            r_stalled <= s_axis_tvalid & ~r_tready;
            if (w_beat) begin
                r_hold <= c_HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - c_HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        r_prev_tdata <= s_axis_tdata;
        r_prev_tstrb <= s_axis_tstrb;
        r_prev_tuser <= s_axis_tuser;
        r_prev_tlast <= s_axis_tlast;
    end

    always_ff @(posedge aclk) begin
        if (reset || clear_stats) begin
            r_state        <= c_ST_IDLE;
            r_pkt_bytes    <= 17'd0;
            r_pkt_count    <= '0;
            r_byte_count   <= '0;
            r_last_pkt_len <= 16'd0;
            r_err          <= 4'd0;
        end else begin
            r_err <= r_err | {w_len_err, w_stall_change, w_tvalid_drop, w_beat & w_strb_bad};
            if (w_beat) begin
                if (s_axis_tlast) begin
                    r_state        <= c_ST_IDLE;
                    r_pkt_bytes    <= 17'd0;
                    r_pkt_count    <= r_pkt_count + C_COUNTER_WIDTH'(1);
                    r_byte_count   <= w_byte_sat;
                    r_last_pkt_len <= w_pkt_len[15:0];
                end else begin
                    r_state     <= c_ST_IN_PKT;
                    r_pkt_bytes <= w_pkt_len;
                end
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign pkt_count     = r_pkt_count;
    assign byte_count    = r_byte_count;
    assign last_pkt_len  = r_last_pkt_len;
    assign activity_rec  = (r_hold != '0);
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nf10_axis_stream_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nf10_axis_stream_monitor
// Brief    : Randomised self-checking bench; instance a = always ready,
//            instance b = LFSR backpressure with an 8-bit byte counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nf10_axis_stream_monitor;

    localparam int          c_DW   = 256;
    localparam int          c_SW   = 32;
    localparam int          c_UW   = 128;
    localparam int          c_HOLD = 16;
    localparam logic [15:0] c_SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [c_DW-1:0] tdata  [2];
    logic [c_SW-1:0] tstrb  [2];
    logic [c_UW-1:0] tuser  [2];
    logic            tvalid [2];
    logic            tlast  [2];
    logic            clr    [2];

    logic        w_tready_a, w_tready_b;
    logic [7:0]  w_pkt_count_a, w_pkt_count_b;
    logic [31:0] w_byte_count_a;
    logic [7:0]  w_byte_count_b;
    logic [15:0] w_last_len_a, w_last_len_b;
    logic        w_activity_a, w_activity_b;
    logic [3:0]  w_err_a, w_err_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nf10_axis_stream_monitor #(.C_TREADY_MODE(0)) u_dut_a (
        .aclk(clk), .reset(rst),
        .s_axis_tdata(tdata[0]), .s_axis_tstrb(tstrb[0]), .s_axis_tuser(tuser[0]),
        .s_axis_tvalid(tvalid[0]), .s_axis_tready(w_tready_a), .s_axis_tlast(tlast[0]),
        .clear_stats(clr[0]), .pkt_count(w_pkt_count_a), .byte_count(w_byte_count_a),
        .last_pkt_len(w_last_len_a), .activity_rec(w_activity_a), .err(w_err_a)
    );

    nf10_axis_stream_monitor #(.C_TREADY_MODE(1), .C_BYTE_COUNT_WIDTH(8)) u_dut_b (
        .aclk(clk), .reset(rst),
        .s_axis_tdata(tdata[1]), .s_axis_tstrb(tstrb[1]), .s_axis_tuser(tuser[1]),
        .s_axis_tvalid(tvalid[1]), .s_axis_tready(w_tready_b), .s_axis_tlast(tlast[1]),
        .clear_stats(clr[1]), .pkt_count(w_pkt_count_b), .byte_count(w_byte_count_b),
        .last_pkt_len(w_last_len_b), .activity_rec(w_activity_b), .err(w_err_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic            rdy;
        logic [15:0]     lfsr;
        logic            in_pkt;
        int              acc;
        int              exp_len;
        int              pkts;
        longint          bytes;
        int              last_len;
        logic [3:0]      err;
        logic            prev_stalled;
        logic [c_DW-1:0] pdata;
        logic [c_SW-1:0] pstrb;
        logic [c_UW-1:0] puser;
        logic            plast;
        longint          last_beat;
    } model_t;

    model_t m [2];
    longint cyc    = 0;
    bit     chk_en = 0;

    function automatic longint byte_max(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'd255;
    endfunction

    task automatic model_step(input int i);
        logic        beat;
        int          n;
        logic [63:0] mask;
        n    = $countones(tstrb[i]);
        mask = (64'd1 << n) - 64'd1;
        if (rst) begin
            m[i].rdy = 1'b0; m[i].lfsr = c_SEED; m[i].in_pkt = 1'b0; m[i].acc = 0;
            m[i].pkts = 0; m[i].bytes = 0; m[i].last_len = 0; m[i].err = 4'd0;
            m[i].prev_stalled = 1'b0; m[i].last_beat = -1000;
        end else begin
            beat = tvalid[i] && m[i].rdy;
            if (beat) m[i].last_beat = cyc;
            if (clr[i]) begin
                m[i].pkts = 0; m[i].bytes = 0; m[i].last_len = 0; m[i].err = 4'd0;
                m[i].in_pkt = 1'b0; m[i].acc = 0;
            end else begin
                if (beat && ((tstrb[i] != 0 && 64'(tstrb[i]) != mask) || (tstrb[i] == 0 && !tlast[i])))
                    m[i].err[0] = 1'b1;
                if (m[i].prev_stalled && !tvalid[i])
                    m[i].err[1] = 1'b1;
                if (m[i].prev_stalled && tvalid[i] && (tdata[i] != m[i].pdata || tstrb[i] != m[i].pstrb ||
                                                       tuser[i] != m[i].puser || tlast[i] != m[i].plast))
                    m[i].err[2] = 1'b1;
                if (beat) begin
                    if (!m[i].in_pkt) begin
                        m[i].acc     = 0;
                        m[i].exp_len = int'(tuser[i][15:0]);
                    end
                    m[i].acc += n;
                    if (tlast[i]) begin
                        m[i].pkts++;
                        m[i].bytes = m[i].bytes + m[i].acc;
                        if (m[i].bytes > byte_max(i)) m[i].bytes = byte_max(i);
                        m[i].last_len = m[i].acc % 65536;
`ifdef NF10_AXIS_MON_LEN_CHECK_EN
                        if (m[i].acc != m[i].exp_len) m[i].err[3] = 1'b1;
`endif
                        m[i].in_pkt = 1'b0;
                        m[i].acc    = 0;
                    end else begin
                        m[i].in_pkt = 1'b1;
                    end
                end
            end
            m[i].prev_stalled = tvalid[i] && !m[i].rdy;
            m[i].rdy  = (i == 0) ? 1'b1 : (m[i].lfsr[1:0] != 2'b00);
            m[i].lfsr = m[i].lfsr[0] ? ((m[i].lfsr >> 1) ^ 16'hB400) : (m[i].lfsr >> 1);
        end
        m[i].pdata = tdata[i]; m[i].pstrb = tstrb[i]; m[i].puser = tuser[i]; m[i].plast = tlast[i];
    endtask

    function automatic logic act_exp(input int i);
        return (cyc >= m[i].last_beat) && (cyc - m[i].last_beat < c_HOLD);
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
        if (rst) chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("tready_a",     w_tready_a,     m[0].rdy);
            check_eq("pkt_count_a",  w_pkt_count_a,  64'(m[0].pkts % 256));
            check_eq("byte_count_a", w_byte_count_a, m[0].bytes);
            check_eq("last_len_a",   w_last_len_a,   64'(m[0].last_len));
            check_eq("activity_a",   w_activity_a,   act_exp(0));
            check_eq("err_a",        w_err_a,        m[0].err);
            check_eq("tready_b",     w_tready_b,     m[1].rdy);
            check_eq("pkt_count_b",  w_pkt_count_b,  64'(m[1].pkts % 256));
            check_eq("byte_count_b", w_byte_count_b, m[1].bytes);
            check_eq("last_len_b",   w_last_len_b,   64'(m[1].last_len));
            check_eq("activity_b",   w_activity_b,   act_exp(1));
            check_eq("err_b",        w_err_b,        m[1].err);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic get_rdy(input int i);
        return (i == 0) ? w_tready_a : w_tready_b;
    endfunction

    function automatic logic [c_DW-1:0] rand_data();
        logic [c_DW-1:0] d;
        for (int k = 0; k < c_DW/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [c_UW-1:0] rand_user(input int len);
        logic [c_UW-1:0] u;
        for (int k = 0; k < c_UW/32; k++) u[k*32 +: 32] = $urandom;
        u[15:0] = 16'(len);
        return u;
    endfunction

    task automatic wait_accept(input int i);
        logic r;
        int   n;
        r = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            r = get_rdy(i);
            @(posedge clk);
            #1;
            clr[i] = 1'b0;
            n++;
        end while (!r && n < 500);
        check_eq("beat_accept", r, 1'b1);
        tvalid[i] = 1'b0;
    endtask

    task automatic send_beat(input int i, input logic [c_DW-1:0] d, input logic [c_SW-1:0] s,
                             input logic [c_UW-1:0] u, input logic l);
        tdata[i] = d; tstrb[i] = s; tuser[i] = u; tlast[i] = l; tvalid[i] = 1'b1;
        wait_accept(i);
    endtask

    task automatic send_pkt(input int i, input int nbytes, input int ulen, input bit rnd_strb);
        int              rem;
        int              nb;
        logic [63:0]     t;
        logic [c_SW-1:0] s;
        rem = nbytes;
        while (rem > 0) begin
            nb = (rem > 32) ? 32 : rem;
            t  = (64'd1 << nb) - 64'd1;
            s  = t[c_SW-1:0];
            if (rnd_strb && $urandom_range(0, 7) == 0) s = $urandom;
            send_beat(i, rand_data(), s, rand_user(ulen), rem <= 32);
            rem -= nb;
        end
    endtask

    task automatic pulse_clear(input int i);
        clr[i] = 1'b1;
        @(posedge clk);
        #1;
        clr[i] = 1'b0;
    endtask

    task automatic stall_fault(input int kind);
        logic r;
        int   n;
        bit   done;
        n = 0;
        done = 1'b0;
        tstrb[1] = '1; tlast[1] = 1'b1; tuser[1] = rand_user(32); tdata[1] = rand_data(); tvalid[1] = 1'b1;
        while (!done && n < 500) begin
            @(negedge clk);
            r = w_tready_b;
            @(posedge clk);
            #1;
            n++;
            if (!r) done = 1'b1;
            else tdata[1] = rand_data();
        end
        check_eq("stall_seen", done, 1'b1);
        if (kind == 0) begin
            tvalid[1] = 1'b0;
        end else begin
            tdata[1][0] = ~tdata[1][0];
            wait_accept(1);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rdy_cnt;
        int act_cnt;
        int len;
        int ulen;
        int k;
        for (int i = 0; i < 2; i++) begin
            tdata[i] = '0; tstrb[i] = '0; tuser[i] = '0; tvalid[i] = 1'b0; tlast[i] = 1'b0; clr[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tready_a", w_tready_a, 1'b0);
        check_eq("rst_pkt_count_a", w_pkt_count_a, 8'd0);
        check_eq("rst_err_b", w_err_b, 4'd0);
        check_eq("rst_activity_a", w_activity_a, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_pkt(0, 64, 64, 0);
        send_pkt(0, 65, 65, 0);
        send_pkt(0, 1, 1, 0);
        @(negedge clk);
        check_eq("tp1_pkt_count", w_pkt_count_a, 8'd3);
        check_eq("tp1_byte_count", w_byte_count_a, 32'd130);
        check_eq("tp1_last_len", w_last_len_a, 16'd1);
        check_eq("tp1_err", w_err_a, 4'd0);

        @(posedge clk);
        #1;
        tdata[1] = rand_data(); tstrb[1] = '1; tuser[1] = rand_user(32); tlast[1] = 1'b1; tvalid[1] = 1'b1;
        rdy_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            rdy_cnt += int'(w_tready_b);
        end
        @(posedge clk);
        #1;
        tvalid[1] = 1'b0;
        check_eq("ready_ratio_in_range", (rdy_cnt >= 700 && rdy_cnt <= 800), 1'b1);
        @(negedge clk);
        check_eq("lfsr_run_err", w_err_b, 4'd0);

        @(posedge clk);
        #1;
        pulse_clear(1);
        stall_fault(0);
        send_pkt(1, 32, 32, 0);
        send_pkt(1, 32, 32, 0);
        stall_fault(1);
        @(negedge clk);
        check_eq("fault_err", w_err_b, 4'b0110);
        @(posedge clk);
        #1;
        pulse_clear(1);
        @(negedge clk);
        check_eq("clr_err", w_err_b, 4'd0);
        check_eq("clr_pkt_count", w_pkt_count_b, 8'd0);
        check_eq("clr_byte_count", w_byte_count_b, 8'd0);
        check_eq("clr_last_len", w_last_len_b, 16'd0);

        @(posedge clk);
        #1;
        repeat (10) send_pkt(1, 32, 32, 0);
        @(negedge clk);
        check_eq("sat_byte_count", w_byte_count_b, 8'd255);
        check_eq("sat_pkt_count", w_pkt_count_b, 8'd10);

        @(posedge clk);
        #1;
        pulse_clear(0);
        repeat (300) send_pkt(0, 1, 1, 0);
        @(negedge clk);
        check_eq("wrap_pkt_count", w_pkt_count_a, 8'd44);

        @(posedge clk);
        #1;
        send_beat(0, rand_data(), '1, rand_user(128), 1'b0);
        tdata[0] = rand_data(); tstrb[0] = '1; tlast[0] = 1'b0; tvalid[0] = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tvalid[0] = 1'b0;
        send_pkt(0, 32, 32, 0);
        @(negedge clk);
        check_eq("rstmid_pkt_count", w_pkt_count_a, 8'd1);
        check_eq("rstmid_byte_count", w_byte_count_a, 32'd32);

        repeat (20) @(posedge clk);
        #1;
        send_beat(0, rand_data(), 32'h1, rand_user(1), 1'b1);
        act_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            act_cnt += int'(w_activity_a);
        end
        check_eq("activity_len", 64'(act_cnt), 64'd16);

        @(posedge clk);
        #1;
        send_pkt(0, 96, 100, 0);
        @(negedge clk);
`ifdef NF10_AXIS_MON_LEN_CHECK_EN
        check_eq("len_check_err3", w_err_a[3], 1'b1);
`else
        check_eq("len_check_err3", w_err_a[3], 1'b0);
`endif
        check_eq("len_check_err_low", w_err_a[2:0], 3'd0);

        @(posedge clk);
        #1;
        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) clr[k] = 1'b1;
            len  = $urandom_range(1, 100);
            ulen = ($urandom_range(0, 3) == 0) ? len + 1 : len;
            send_pkt(k, len, ulen, k == 1);
        end

        repeat (20) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
